// File: rtl/dyt_pkg.sv
// Shared widths, register count and the result-holding record for the writeback path.
package dyt_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

endpackage

// File: rtl/dyt_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module dyt_scoreboard
    import dyt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_a_addr,
    input  logic [ADDR_WIDTH-1:0] rd_b_addr,
    output logic                  rd_a_busy,
    output logic                  rd_b_busy
);

    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:0] busy_v;

    // A reservation landing on the same edge as the retiring write must survive it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && set_addr == ADDR_WIDTH'(i))
                    busy_q[i] <= 1'b1;
                else if (clr_en && clr_addr == ADDR_WIDTH'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign busy_v    = {busy_q, 1'b0};
    assign rd_a_busy = busy_v[rd_a_addr];
    assign rd_b_busy = busy_v[rd_b_addr];

endmodule

// File: rtl/dyt_writeback_arbiter.sv
// Round-robin ALU/LSU writeback onto the single register-file write port, with hazard scoreboard.
// Optional DYT_WB_BYPASS_EN adds forwarding of the in-flight write to read ports A and B.
module dyt_writeback_arbiter
    import dyt_pkg::*;
#(
    parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dyt_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs_a_addr,
    input  logic [ADDR_WIDTH-1:0] rs_b_addr,
    output logic                  rs_a_busy,
    output logic                  rs_b_busy,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data
`ifdef DYT_WB_BYPASS_EN
    ,
    output logic                  rs_a_fwd,
    output logic                  rs_b_fwd,
    output logic [DATA_WIDTH-1:0] rs_a_fwd_data,
    output logic [DATA_WIDTH-1:0] rs_b_fwd_data
`endif
);

    wb_req_t alu_hold_p0;
    wb_req_t lsu_hold_p0;
    grant_t  last_grant;
    logic    grant_alu;
    logic    grant_lsu;
    logic    sb_busy_a;
    logic    sb_busy_b;

    assign grant_alu = alu_hold_p0.valid && (!lsu_hold_p0.valid || last_grant == GNT_LSU);
    assign grant_lsu = lsu_hold_p0.valid && (!alu_hold_p0.valid || last_grant == GNT_ALU);

    assign alu_ready = rst && (!alu_hold_p0.valid || grant_alu);
    assign lsu_ready = rst && (!lsu_hold_p0.valid || grant_lsu);

    // Stage p0: channel holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_hold_p0 <= '0;
            lsu_hold_p0 <= '0;
        end else begin
            if (alu_valid && alu_ready)
                alu_hold_p0 <= '{valid: 1'b1, rd: alu_rd, data: alu_data};
            else if (grant_alu)
                alu_hold_p0.valid <= 1'b0;

            if (lsu_valid && lsu_ready)
                lsu_hold_p0 <= '{valid: 1'b1, rd: lsu_rd, data: lsu_data};
            else if (grant_lsu)
                lsu_hold_p0.valid <= 1'b0;
        end
    end

    // Stage p1: arbitration winner drives the write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            last_grant <= GNT_ALU;
        end else if (grant_lsu) begin
            w_en       <= (lsu_hold_p0.rd != '0);
            w_addr     <= lsu_hold_p0.rd;
            w_data     <= lsu_hold_p0.data;
            last_grant <= GNT_LSU;
        end else if (grant_alu) begin
            w_en       <= (alu_hold_p0.rd != '0);
            w_addr     <= alu_hold_p0.rd;
            w_data     <= alu_hold_p0.data;
            last_grant <= GNT_ALU;
        end else begin
            w_en       <= 1'b0;
        end
    end

    dyt_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_valid && iss_rd != '0),
        .set_addr  (iss_rd),
        .clr_en    (w_en),
        .clr_addr  (w_addr),
        .rd_a_addr (rs_a_addr),
        .rd_b_addr (rs_b_addr),
        .rd_a_busy (sb_busy_a),
        .rd_b_busy (sb_busy_b)
    );

`ifdef DYT_WB_BYPASS_EN
    // The write in flight this cycle satisfies the hazard directly.
    assign rs_a_fwd      = w_en && w_addr == rs_a_addr && rs_a_addr != '0;
    assign rs_b_fwd      = w_en && w_addr == rs_b_addr && rs_b_addr != '0;
    assign rs_a_fwd_data = w_data;
    assign rs_b_fwd_data = w_data;
    assign rs_a_busy     = sb_busy_a && !rs_a_fwd;
    assign rs_b_busy     = sb_busy_b && !rs_b_fwd;
`else
    assign rs_a_busy     = sb_busy_a;
    assign rs_b_busy     = sb_busy_b;
`endif

endmodule
